// File: rtl/pmbus_pkg.sv
// Shared PMBus definitions: command codes, STATUS_BYTE bit positions and the
// command-register FSM state encoding.
package pmbus_pkg;

  localparam logic [7:0] CMD_PAGE         = 8'h00;
  localparam logic [7:0] CMD_OPERATION    = 8'h01;
  localparam logic [7:0] CMD_CLEAR_FAULTS = 8'h03;
  localparam logic [7:0] CMD_STATUS_BYTE  = 8'h78;
  localparam logic [7:0] CMD_READ_VOUT    = 8'h8B;

  localparam int STS_OFF     = 6;
  localparam int STS_VOUT_OV = 5;
  localparam int STS_CML     = 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TLM_WAIT,
    ST_DONE
  } state_t;

  function automatic logic [7:0] status_byte(input logic off, input logic ov, input logic cml);
    logic [7:0] s;
    s              = '0;
    s[STS_OFF]     = off;
    s[STS_VOUT_OV] = ov;
    s[STS_CML]     = cml;
    return s;
  endfunction

endpackage

// File: rtl/pmbus_cmd_regs.sv
// PMBus command register block: per-page PAGE/OPERATION/STATUS_BYTE state,
// fault capture, and READ_VOUT served through a telemetry request/ack handshake.
module pmbus_cmd_regs
  import pmbus_pkg::*;
#(
  parameter int MAX_BYTES   = 2,
  parameter int NUM_PAGES   = 4,
  parameter int TLM_TIMEOUT = 255
) (
  input  logic                         CLOCK,
  input  logic                         RESET_N,
  input  logic [7:0]                   SMB_COMMAND,
  input  logic [MAX_BYTES-1:0]         SMB_BYTEEN,
  input  logic                         SMB_STOP,
  input  logic                         SMB_READ,
  input  logic                         SMB_WRITE,
  output logic                         SMB_WAITREQUEST,
  output logic [MAX_BYTES*8-1:0]       SMB_READDATA,
  input  logic [MAX_BYTES*8-1:0]       SMB_WRITEDATA,
  output logic [NUM_PAGES-1:0]         OPERATION_ON,
  input  logic [NUM_PAGES-1:0]         FAULT_IN,
  output logic                         TLM_REQ,
  output logic [$clog2(NUM_PAGES)-1:0] TLM_PAGE,
  input  logic                         TLM_ACK,
  input  logic [15:0]                  TLM_DATA
);

  localparam int         DW       = MAX_BYTES * 8;
  localparam int         PW       = $clog2(NUM_PAGES);
  localparam logic [7:0] TLM_LAST = 8'(TLM_TIMEOUT - 1);

  state_t               state;
  logic [PW-1:0]        page;
  logic [NUM_PAGES-1:0] op_on, vout_ov, cml;
  logic [7:0]           tlm_cnt;
  logic                 wait_q, tlm_req_q;
  logic [DW-1:0]        rdata_q;
  logic [7:0]           reg_rdata;
  logic                 rd_known;
  logic                 unused_inputs;

  assign unused_inputs   = ^{SMB_STOP, SMB_BYTEEN, SMB_WRITEDATA};
  assign SMB_WAITREQUEST = wait_q;
  assign SMB_READDATA    = rdata_q;
  assign OPERATION_ON    = op_on;
  assign TLM_REQ         = tlm_req_q;
  assign TLM_PAGE        = page;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    reg_rdata = '0;
    rd_known  = 1'b1;
    case (SMB_COMMAND)
      CMD_PAGE:        reg_rdata = 8'(page);
      CMD_OPERATION:   reg_rdata = {op_on[page], 7'b0};
      CMD_STATUS_BYTE: reg_rdata = status_byte(~op_on[page], vout_ov[page], cml[page]);
      default:         rd_known  = 1'b0;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= ST_IDLE;
      wait_q    <= 1'b1;
      rdata_q   <= '0;
      tlm_req_q <= 1'b0;
      tlm_cnt   <= '0;
      page      <= '0;
      op_on     <= '0;
      vout_ov   <= '0;
      cml       <= '0;
    end else begin
      // NOTE: non-blocking assignments; the fault loop below is last, so its assignments win at the same edge.
      case (state)
        ST_IDLE: begin
          if (SMB_WRITE) begin
            state  <= ST_DONE;
            wait_q <= 1'b0;
            case (SMB_COMMAND)
              CMD_PAGE:
                if (!SMB_BYTEEN[0] || SMB_WRITEDATA[7:0] >= 8'(NUM_PAGES)) cml[page] <= 1'b1;
                else page <= SMB_WRITEDATA[PW-1:0];
              CMD_OPERATION:
                if (!SMB_BYTEEN[0]) cml[page] <= 1'b1;
                else op_on[page] <= SMB_WRITEDATA[7];
              CMD_CLEAR_FAULTS: begin
                vout_ov[page] <= 1'b0;
                cml[page]     <= 1'b0;
              end
              default: cml[page] <= 1'b1;
            endcase
          end else if (SMB_READ) begin
            if (SMB_COMMAND == CMD_READ_VOUT) begin
              state     <= ST_TLM_WAIT;
              tlm_req_q <= 1'b1;
              tlm_cnt   <= '0;
            end else begin
              state   <= ST_DONE;
              wait_q  <= 1'b0;
              rdata_q <= DW'(reg_rdata);
              if (!rd_known) cml[page] <= 1'b1;
            end
          end
        end
        ST_TLM_WAIT: begin
          if (TLM_ACK) begin
            state     <= ST_DONE;
            wait_q    <= 1'b0;
            tlm_req_q <= 1'b0;
            rdata_q   <= DW'(TLM_DATA);
          end else if (tlm_cnt == TLM_LAST) begin
            state     <= ST_DONE;
            wait_q    <= 1'b0;
            tlm_req_q <= 1'b0;
            rdata_q   <= DW'(16'hFFFF);
            cml[page] <= 1'b1;
          end else begin
            tlm_cnt <= tlm_cnt + 8'd1;
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          wait_q <= 1'b1;
        end
        default: begin
          state     <= ST_IDLE;
          wait_q    <= 1'b1;
          tlm_req_q <= 1'b0;
        end
      endcase
      for (int p = 0; p < NUM_PAGES; p++) begin
        if (FAULT_IN[p]) begin
          vout_ov[p] <= 1'b1;
          op_on[p]   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/pmbus_cmd_regs.md
PMBUS_CMD_REGS -- requirements
Module: pmbus_cmd_regs

Interface
REQ-001 Parameter MAX_BYTES, default 2, data bus width in bytes; SHALL match the upstream PMBus slave bridge.
REQ-002 Parameter NUM_PAGES, default 4, number of rails/pages; legal range 2..16.
REQ-003 Parameter TLM_TIMEOUT, default 255, maximum clocks to wait for TLM_ACK.
REQ-004 CLOCK  in  1  system clock; all logic is on its rising edge.
REQ-005 RESET_N  in  1  reset, asynchronous, active-low.
REQ-006 SMB_COMMAND  in  8  PMBus command code.
REQ-007 SMB_BYTEEN  in  MAX_BYTES  write byte enables.
REQ-008 SMB_STOP  in  1  end-of-command strobe; reserved, no function.
REQ-009 SMB_READ  in  1  read request; held until SMB_WAITREQUEST is low.
REQ-010 SMB_WRITE  in  1  write request; held until SMB_WAITREQUEST is low.
REQ-011 SMB_WAITREQUEST  out  1  stall; low exactly one cycle per completed access.
REQ-012 SMB_READDATA  out  MAX_BYTES*8  read response; valid while SMB_WAITREQUEST is low.
REQ-013 SMB_WRITEDATA  in  MAX_BYTES*8  write payload, byte 0 in bits [7:0].
REQ-014 OPERATION_ON  out  NUM_PAGES  per-rail enable to the sequencer.
REQ-015 FAULT_IN  in  NUM_PAGES  per-rail fault, level; synchronous to CLOCK.
REQ-016 TLM_REQ  out  1  telemetry request, held until TLM_ACK or timeout.
REQ-017 TLM_PAGE  out  clog2(NUM_PAGES)  page being sampled; stable while TLM_REQ is high.
REQ-018 TLM_ACK  in  1  single-cycle telemetry-valid strobe.
REQ-019 TLM_DATA  in  16  VOUT sample, LINEAR16; sampled when TLM_ACK is high.

Function
REQ-020 FSM states: ST_IDLE, ST_TLM_WAIT, ST_DONE; SMB_WAITREQUEST SHALL be high in every state except ST_DONE.
REQ-021 ST_IDLE, SMB_WRITE high: apply the write at that edge, then go to ST_DONE; if SMB_READ is also high, the write is served and the read is served on the next pass through ST_IDLE.
REQ-022 ST_IDLE, SMB_READ high: for a register command, register SMB_READDATA and go to ST_DONE, giving WAITREQUEST low 1 cycle after READ rises; for READ_VOUT (0x8B), go to ST_TLM_WAIT.
REQ-023 ST_DONE SHALL last one cycle and then return to ST_IDLE; SMB_READDATA SHALL hold its value until the next read completes.
REQ-024 ST_TLM_WAIT: TLM_REQ high and TLM_PAGE = current PAGE; on TLM_ACK, latch {16'b0 padded to the bus, TLM_DATA} into SMB_READDATA and go to ST_DONE.
REQ-025 ST_TLM_WAIT timeout: after TLM_TIMEOUT cycles with no TLM_ACK, return 16'hFFFF, set CML for the page, and go to ST_DONE; an 8-bit counter clears on entry.
REQ-026 PAGE (0x00), R/W byte: a write with value >= NUM_PAGES is ignored and sets CML on the current page.
REQ-027 OPERATION (0x01), R/W byte, per current page: bit7 drives OPERATION_ON[page]; a read returns 8'h80 or 8'h00.
REQ-028 CLEAR_FAULTS (0x03), send-byte (write, BYTEEN=0): clear the sticky bits of the current page only.
REQ-029 STATUS_BYTE (0x78), read-only, per page: bit6 OFF = ~OPERATION_ON (live), bit5 VOUT_OV sticky, bit1 CML sticky, all other bits 0.
REQ-030 A FAULT_IN[p] high cycle SHALL set VOUT_OV[p] and clear OPERATION_ON[p] at the same edge; a fault in the same cycle as CLEAR_FAULTS leaves the bit set.
REQ-031 The following SHALL set CML on the current page: an unsupported command read (returns 0); a write to a read-only or unsupported command (ignored); a byte-command write with BYTEEN[0]=0.
REQ-032 Upper unused SMB_READDATA bytes SHALL read 0.

Reset
REQ-033 On RESET_N low: ST_IDLE; SMB_WAITREQUEST=1; SMB_READDATA=0; TLM_REQ=0; PAGE=0; OPERATION_ON=0; all status bits=0; timeout counter=0.
REQ-034 Reset asserted mid-telemetry SHALL drop TLM_REQ immediately; a TLM_ACK after reset SHALL be ignored.

Structure
REQ-035 Shared package pmbus_pkg SHALL hold command codes, STATUS_BYTE bit positions and the FSM state enum.
REQ-036 The block SHALL be a single module with no sub-module; per-page state SHALL be NUM_PAGES-wide arrays indexed by PAGE.

Verification
REQ-037 Write OPERATION=0x80 on page 2, then read OPERATION -> OPERATION_ON=4'b0100, readdata 8'h80, WAITREQUEST low for 1 cycle.
REQ-038 Read READ_VOUT on page 1, TLM_ACK 5 cycles later with 0x1234 -> TLM_PAGE=1, readdata 16'h1234.
REQ-039 Read READ_VOUT with no TLM_ACK -> WAITREQUEST low after TLM_TIMEOUT+1 cycles, readdata 16'hFFFF, STATUS_BYTE[1]=1.
REQ-040 Pulse FAULT_IN[0] with page 0 on -> OPERATION_ON[0]=0, STATUS_BYTE=8'h60; CLEAR_FAULTS -> 8'h40.
REQ-041 Write PAGE=7 with NUM_PAGES=4 -> PAGE stays 0, CML set on page 0.
REQ-042 Assert reset during ST_TLM_WAIT, then drive TLM_ACK -> TLM_REQ=0, no access completes, all outputs at reset values.
